// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the multi-cycle MUL/UDIV sequencer: word width, ALU opcodes,
// op encodings, iteration count and FSM state encoding.
package muldiv_sequencer_pkg;

    localparam int unsigned WORD = 64;

    localparam logic [3:0] ALU_ADD      = 4'b0010;
    localparam logic [3:0] ALU_SUBTRACT = 4'b0110;

    localparam logic MULDIV_OP_MUL  = 1'b0;
    localparam logic MULDIV_OP_UDIV = 1'b1;

    localparam int unsigned MULDIV_ITERS = 64;
    localparam int unsigned CNT_W        = $clog2(MULDIV_ITERS);

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_RUN  = 2'd1,
        MULDIV_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences 64-bit MUL (low word) and restoring UDIV on the shared ALU, one step per clock.
// Optional macro MULDIV_EARLY_EXIT_EN ends MUL as soon as the multiplier is exhausted.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op,
    input  logic [WORD-1:0] operand_a,
    input  logic [WORD-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] result,
    output logic            div_by_zero,
    output logic [WORD-1:0] alu_a,
    output logic [WORD-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [WORD-1:0] alu_result
);

    muldiv_state_t state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: MUL accumulator / UDIV remainder; opnd: multiplicand / divisor;
    // shreg: multiplier / dividend-then-quotient.
    logic [WORD-1:0]  acc_q, acc_d;
    logic [WORD-1:0]  opnd_q, opnd_d;
    logic [WORD-1:0]  shreg_q, shreg_d;
    logic [WORD-1:0]  result_q, result_d;
    logic             dbz_q, dbz_d;

    logic [WORD-1:0]  rem_sh;
    logic             carry;
    logic             last_step;

    assign rem_sh = {acc_q[WORD-2:0], shreg_q[WORD-1]};
    assign carry  = acc_q[WORD-1];

    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == MULDIV_RUN) || (state_q == MULDIV_DONE);
    assign done        = (state_q == MULDIV_DONE);

    // Kept free of alu_result so the parent's ALU path is not a loop through this block.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        if (state_q == MULDIV_RUN) begin
            alu_b = opnd_q;
            if (op_q == MULDIV_OP_UDIV) begin
                alu_a       = rem_sh;
                alu_control = ALU_SUBTRACT;
            end else begin
                alu_a = acc_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        last_step = 1'b0;

        unique case (state_q)
            MULDIV_IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    opnd_d  = (op == MULDIV_OP_UDIV) ? operand_b : operand_a;
                    shreg_d = (op == MULDIV_OP_UDIV) ? operand_a : operand_b;
                    if ((op == MULDIV_OP_UDIV) && (operand_b == '0)) begin
                        state_d  = MULDIV_DONE;
                        result_d = '0;
                        dbz_d    = 1'b1;
                    end
`ifdef MULDIV_EARLY_EXIT_EN
                    else if ((op == MULDIV_OP_MUL) && (operand_b == '0)) begin
                        state_d  = MULDIV_DONE;
                        result_d = '0;
                        dbz_d    = 1'b0;
                    end
`endif
                    else begin
                        state_d = MULDIV_RUN;
                    end
                end
            end

            MULDIV_RUN: begin
                cnt_d     = cnt_q + 1'b1;
                last_step = (cnt_q == CNT_W'(MULDIV_ITERS - 1));
                if (op_q == MULDIV_OP_MUL) begin
                    if (shreg_q[0]) begin
                        acc_d = alu_result;
                    end
                    opnd_d  = opnd_q << 1;
                    shreg_d = shreg_q >> 1;
`ifdef MULDIV_EARLY_EXIT_EN
                    if (shreg_q[WORD-1:1] == '0) begin
                        last_step = 1'b1;
                    end
`endif
                end else begin
                    shreg_d = {shreg_q[WORD-2:0], 1'b0};
                    // The carry out of the shift means rem_sh already exceeds any divisor.
                    if (carry || (rem_sh >= opnd_q)) begin
                        acc_d      = alu_result;
                        shreg_d[0] = 1'b1;
                    end else begin
                        acc_d = rem_sh;
                    end
                end
                if (last_step) begin
                    state_d  = MULDIV_DONE;
                    result_d = (op_q == MULDIV_OP_MUL) ? acc_d : shreg_d;
                    dbz_d    = 1'b0;
                end
            end

            MULDIV_DONE: begin
                state_d = MULDIV_IDLE;
            end

            default: begin
                state_d = MULDIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MULDIV_IDLE;
            op_q     <= MULDIV_OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            shreg_q  <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random ops against an arithmetic model.
// Honours MULDIV_EARLY_EXIT_EN when computing expected latency.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            op;
    logic [WORD-1:0] operand_a;
    logic [WORD-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [WORD-1:0] result;
    logic            div_by_zero;
    logic [WORD-1:0] alu_a;
    logic [WORD-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [WORD-1:0] alu_result;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign alu_result = (alu_control == ALU_SUBTRACT) ? alu_a - alu_b : alu_a + alu_b;

    muldiv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    function automatic logic [WORD-1:0] model_result(input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                                                     input logic o);
        if (o == MULDIV_OP_UDIV) return (b == '0) ? '0 : a / b;
        return a * b;
    endfunction

    // Edges after the start-sampling edge until done is visible.
    function automatic int model_latency(input logic [WORD-1:0] b, input logic o);
        if ((o == MULDIV_OP_UDIV) && (b == '0)) return 0;
`ifdef MULDIV_EARLY_EXIT_EN
        if (o == MULDIV_OP_MUL) begin
            if (b == '0) return 0;
            for (int i = WORD - 1; i >= 0; i--) if (b[i]) return i + 1;
        end
`endif
        return MULDIV_ITERS;
    endfunction

    task automatic issue(input logic [WORD-1:0] a, input logic [WORD-1:0] b, input logic o,
                         output int lat, output logic [WORD-1:0] res, output logic dbz,
                         output logic [3:0] ctl0, output logic busy_after,
                         output logic [WORD-1:0] res_after);
        @(negedge clk);
        operand_a = a;
        operand_b = b;
        op        = o;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ctl0  = alu_control;
        lat   = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        dbz = div_by_zero;
        @(posedge clk);
        #1;
        busy_after = busy;
        res_after  = result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000 || result !== '0 || alu_a !== '0 ||
            alu_b !== '0 || alu_control !== ALU_ADD) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b result=%h alu_a=%h alu_b=%h ctl=%h, need all zero / ctl=%h",
                     busy, done, div_by_zero, result, alu_a, alu_b, alu_control, ALU_ADD);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [WORD-1:0] a,
                                 input logic [WORD-1:0] b, input logic o);
        int lat, elat;
        logic [WORD-1:0] res, eres, res_after;
        logic dbz, busy_after, edbz;
        logic [3:0] ctl0, ectl;
        issue(a, b, o, lat, res, dbz, ctl0, busy_after, res_after);
        elat = model_latency(b, o);
        eres = model_result(a, b, o);
        edbz = (o == MULDIV_OP_UDIV) && (b == '0);
        ectl = (elat == 0) ? ALU_ADD : ((o == MULDIV_OP_UDIV) ? ALU_SUBTRACT : ALU_ADD);
        vectors++;
        if (lat !== elat || res !== eres || dbz !== edbz) begin
            miscompares++;
            $display("FAIL %s: a=%h b=%h op=%b got lat=%0d res=%h dbz=%b, need lat=%0d res=%h dbz=%b",
                     name, a, b, o, lat, res, dbz, elat, eres, edbz);
        end
        vectors++;
        if (ctl0 !== ectl || busy_after !== 1'b0 || res_after !== eres) begin
            miscompares++;
            $display("FAIL %s_aux: first ctl=%h busy_after=%b held=%h, need ctl=%h busy_after=0 held=%h",
                     name, ctl0, busy_after, res_after, ectl, eres);
        end
    endtask

    task automatic test_directed();
        run_and_check("mul_7x6", 64'd7, 64'd6, MULDIV_OP_MUL);
        run_and_check("mul_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULDIV_OP_MUL);
        run_and_check("div_100_7", 64'd100, 64'd7, MULDIV_OP_UDIV);
        run_and_check("div_carry", 64'h8000_0000_0000_0000, 64'd1, MULDIV_OP_UDIV);
        run_and_check("div_by_zero", 64'd5, 64'd0, MULDIV_OP_UDIV);
        run_and_check("mul_3x5", 64'd3, 64'd5, MULDIV_OP_MUL);
        run_and_check("mul_9x0", 64'd9, 64'd0, MULDIV_OP_MUL);
        run_and_check("div_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MULDIV_OP_UDIV);
    endtask

    task automatic test_random();
        logic [WORD-1:0] a, b;
        logic o;
        for (int i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = WORD'($urandom_range(0, 15));
                1:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            o = 1'($urandom_range(0, 1));
            run_and_check("random", a, b, o);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        operand_a = 64'd100;
        operand_b = 64'd7;
        op        = MULDIV_OP_UDIV;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (10) begin
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        operand_a = 64'd11;
        operand_b = 64'd13;
        op        = MULDIV_OP_MUL;
        start     = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== MULDIV_ITERS || result !== 64'd14 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored: lat=%0d res=%h dbz=%b, need lat=%0d res=%h dbz=0",
                     lat, result, div_by_zero, MULDIV_ITERS, 64'd14);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        operand_a = 64'hDEAD_BEEF_1234_5678;
        operand_b = 64'hFFFF_FFFF_FFFF_FFFF;
        op        = MULDIV_OP_MUL;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000 || result !== '0 || alu_a !== '0 ||
            alu_b !== '0 || alu_control !== ALU_ADD) begin
            miscompares++;
            $display("FAIL reset_abort: busy=%b done=%b dbz=%b result=%h alu_a=%h alu_b=%h ctl=%h, need reset values",
                     busy, done, div_by_zero, result, alu_a, alu_b, alu_control);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_beats_start: busy=%b, need 0", busy);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        run_and_check("mul_after_reset", 64'd3, 64'd5, MULDIV_OP_MUL);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, k;
        @(negedge clk);
        operand_a = 64'd7;
        operand_b = 64'd1;
        op        = MULDIV_OP_UDIV;
        start     = 1'b1;
        @(posedge clk);
        #1;
        lat1 = 0;
        while (!done && lat1 < 200) begin
            @(posedge clk);
            #1;
            lat1++;
        end
        lat2 = 0;
        do begin
            @(posedge clk);
            #1;
            lat2++;
        end while (!done && lat2 < 200);
        vectors++;
        if (lat1 !== MULDIV_ITERS || lat2 !== MULDIV_ITERS + 2 || result !== 64'd7) begin
            miscompares++;
            $display("FAIL back_to_back: first=%0d gap=%0d res=%h, need first=%0d gap=%0d res=%h",
                     lat1, lat2, result, MULDIV_ITERS, MULDIV_ITERS + 2, 64'd7);
        end
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
